softmax_norm_sequencer: RTL

//  Softmax normalisation front-end. Collects one vector of VEC_LEN exp() values (S5.10),

---
 rtl/softmax_norm_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/softmax_norm_sequencer.sv
// -----------------------------------------------------------------------------
// softmax_norm_sequencer
//   Softmax normalisation front-end.
//   Flow:
//     1. Collect one vector of VEC_LEN exp() values (S5.10). Negative inputs are
//        clamped to 0.
//     2. Accumulate their sum (S13.10). The sum saturates and does not wrap.
//     3. Run one external division per element (element / sum).
//     4. Stream the S5.10 quotients downstream over a valid/ready handshake.
//   A vector whose sum is zero skips the divider and emits VEC_LEN zeros.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      element input (ready only while loading)
//   div_start/div_num/div_den      request to the divider (one outstanding)
//   div_quot/div_valid             divider response
//   out_valid/out_ready/out_data   probability output, out_last on final element
//   err                            sticky divider-timeout flag
//
// Build option
//   SOFTMAX_DIV_TIMEOUT_EN : when defined, WAIT gives up after DIV_TIMEOUT
//                            cycles, emits 0 and sets err. When undefined,
//                            WAIT blocks until div_valid and err is tied to 0.
// -----------------------------------------------------------------------------
module softmax_norm_sequencer #(
  parameter int VEC_LEN     = 8,
  parameter int DATA_W      = 16,
  parameter int SUM_W       = 24,
  parameter int DIV_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              div_start,
  output logic [DATA_W-1:0] div_num,
  output logic [SUM_W-1:0]  div_den,
  input  logic [DATA_W-1:0] div_quot,
  input  logic              div_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err
);

  localparam int              IW      = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IW-1:0]   LAST    = IW'(VEC_LEN - 1);
  localparam logic [SUM_W:0]  SUM_MAX = {2'b00, {(SUM_W-1){1'b1}}};

  typedef enum logic [2:0] {LOAD, ISSUE, WAIT, OUT, ZOUT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [VEC_LEN];
  logic [IW-1:0]     count, idx, idx_nx;
  logic [SUM_W-1:0]  sum, sum_nx;
  logic [SUM_W:0]    sum_add;
  logic [DATA_W-1:0] elem_c;
  logic              accept;

  // Negative exp() values are nonsensical upstream artefacts; treat them as 0.
  assign elem_c  = in_data[DATA_W-1] ? '0 : in_data;
  assign accept  = in_valid & in_ready;
  assign sum_add = {1'b0, sum} + (SUM_W+1)'(elem_c);
  assign sum_nx  = (sum_add > SUM_MAX) ? SUM_MAX[SUM_W-1:0] : sum_add[SUM_W-1:0];
  assign idx_nx  = idx + 1'b1;

  // Element buffer. It needs no reset: count restarts at 0, so stale entries
  // are always overwritten before they are read.
  always_ff @(posedge clk) begin
    if (accept) mem[count] <= elem_c;
  end

`ifdef SOFTMAX_DIV_TIMEOUT_EN
  localparam int            TW   = $clog2(DIV_TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(DIV_TIMEOUT - 1);
  logic [TW-1:0] tcnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      count     <= '0;
      idx       <= '0;
      sum       <= '0;
      in_ready  <= 1'b1;
      div_start <= 1'b0;
      div_num   <= '0;
      div_den   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef SOFTMAX_DIV_TIMEOUT_EN
      tcnt      <= '0;
      err       <= 1'b0;
`endif
    end else begin
      div_start <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            sum   <= sum_nx;
            count <= count + 1'b1;
            if (count == LAST) begin
              // Last element: start the first division right away, so
              // div_start is high in the cycle after the final accept.
              // mem[0] was written on an earlier edge.
              in_ready <= 1'b0;
              count    <= '0;
              idx      <= '0;
              if (sum_nx == '0) begin
                state     <= ZOUT;
                out_valid <= 1'b1;
                out_data  <= '0;
                out_last  <= 1'b0;
              end else begin
                state     <= ISSUE;
                div_start <= 1'b1;
                div_num   <= mem[0];
                div_den   <= sum_nx;
              end
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef SOFTMAX_DIV_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        WAIT: begin
          if (div_valid) begin
            out_data  <= div_quot;
            out_valid <= 1'b1;
            out_last  <= (idx == LAST);
            state     <= OUT;
          end
`ifdef SOFTMAX_DIV_TIMEOUT_EN
          // tcnt == k-1 in the k-th cycle after div_start.
          else if (tcnt == TLIM) begin
            out_data  <= '0;
            out_valid <= 1'b1;
            out_last  <= (idx == LAST);
            err       <= 1'b1;
            state     <= OUT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx == LAST) begin
              state    <= LOAD;
              in_ready <= 1'b1;
              idx      <= '0;
              count    <= '0;
              sum      <= '0;
            end else begin
              idx       <= idx_nx;
              div_start <= 1'b1;
              div_num   <= mem[idx_nx];
              state     <= ISSUE;
            end
          end
        end
        ZOUT: begin
          // out_valid stays high; out_data is already 0.
          if (out_ready) begin
            if (idx == LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= LOAD;
              in_ready  <= 1'b1;
              idx       <= '0;
              count     <= '0;
              sum       <= '0;
            end else begin
              idx      <= idx_nx;
              out_last <= (idx_nx == LAST);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
